bolt_pool: RTL



---
 rtl/bolt_pool.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/bolt_pool.sv
// -----------------------------------------------------------------------------
// bolt_pool
//
// Projectile manager for the shooter sprites. It holds a pool of NUM_BOLTS
// bolt slots. On each accepted fire request it spawns a bolt at a fixed offset
// from a moving origin. Live bolts move vertically once per frame in sub-pixel
// fixed point. A slot is retired when the collision block reports a hit, or
// when its bolt leaves the visible rows.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   startOfFrame  one-cycle pulse per frame; advances bolts and the cooldown
//   fireReq       fire key/request level; a rising edge requests one shot
//   originX/Y     shooter top-left position, in pixels
//   boltHit       per-slot collision pulse; clears the slot on the next edge
//   boltX/boltY   flattened pixel positions; slot i at [i*COORD_W +: COORD_W]
//   boltActive    per-slot live flag, used to qualify drawing
//   fireAccepted  one-cycle pulse in the cycle a bolt becomes visible
//   activeCount   number of live slots
// -----------------------------------------------------------------------------
module bolt_pool #(
   parameter int NUM_BOLTS       = 4,
   parameter int COORD_W         = 11,
   parameter int FRAC_BITS       = 6,
   parameter int SPEED_Y         = 30,
   parameter int DIRECTION       = -1,
   parameter int OFFSET_X        = 20,
   parameter int OFFSET_Y        = 0,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int Y_MIN           = 0,
   parameter int Y_MAX           = 479
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             startOfFrame,
   input  logic                             fireReq,
   input  logic [COORD_W-1:0]               originX,
   input  logic [COORD_W-1:0]               originY,
   input  logic [NUM_BOLTS-1:0]             boltHit,
   output logic [NUM_BOLTS*COORD_W-1:0]     boltX,
   output logic [NUM_BOLTS*COORD_W-1:0]     boltY,
   output logic [NUM_BOLTS-1:0]             boltActive,
   output logic                             fireAccepted,
   output logic [$clog2(NUM_BOLTS+1)-1:0]   activeCount
);

   // The vertical position carries one extra sign bit above the pixel range.
   // A bolt that runs past the top or bottom stays representable for one more
   // step, so the off-screen compare can see it before it wraps.
   localparam int POS_W = COORD_W + FRAC_BITS + 1;
   localparam int CD_W  = $clog2(COOLDOWN_FRAMES + 2);
   localparam int CNT_W = $clog2(NUM_BOLTS + 1);

   typedef logic signed [POS_W-1:0] pos_t;

   localparam pos_t STEP_Y      = pos_t'(DIRECTION * SPEED_Y * (2 ** FRAC_BITS));
   localparam pos_t Y_MIN_FX    = pos_t'(Y_MIN * (2 ** FRAC_BITS));
   localparam pos_t Y_MAX_FX    = pos_t'(Y_MAX * (2 ** FRAC_BITS));
   localparam pos_t OFFSET_Y_FX = pos_t'(OFFSET_Y * (2 ** FRAC_BITS));
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

   // X never moves, so its fraction is always zero. Only the pixel part is
   // kept, wrapped to COORD_W, which is the same value the output would show.
   logic [COORD_W-1:0]   pos_x_q [NUM_BOLTS];
   logic [COORD_W-1:0]   pos_x_d [NUM_BOLTS];
   pos_t                 pos_y_q [NUM_BOLTS];
   pos_t                 pos_y_d [NUM_BOLTS];
   logic [NUM_BOLTS-1:0] active_q, active_d;
   logic                 fire_req_q, fire_req_d;
   logic [CD_W-1:0]      cooldown_q, cooldown_d;
   logic                 fire_acc_q, fire_acc_d;
   logic [CNT_W-1:0]     count_q, count_d;

   logic                 fire_edge;
   logic                 accept;
   logic [NUM_BOLTS-1:0] spawn_sel;
   logic                 found;
   logic [COORD_W-1:0]   spawn_x;
   pos_t                 spawn_y;
   pos_t                 y_next;
   logic                 off_screen;

   // -------------------------------------------------------------------------
   // Fire arbitration and cooldown
   // -------------------------------------------------------------------------
   // NOTE: every variable written here gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      fire_req_d = fireReq;
      fire_edge  = fireReq & ~fire_req_q;

      // Choose the lowest-index free slot, judged only from the registered
      // flags. A slot freed this cycle becomes eligible in the next cycle.
      spawn_sel = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_BOLTS; i++) begin
         if (!active_q[i] && !found) begin
            spawn_sel[i] = 1'b1;
            found        = 1'b1;
         end
      end

      accept     = fire_edge && (cooldown_q == '0) && found;
      fire_acc_d = accept;

      cooldown_d = cooldown_q;
      if (accept) begin
         cooldown_d = CD_LOAD;
      end else if (startOfFrame && (cooldown_q != '0)) begin
         cooldown_d = cooldown_q - CD_W'(1);
      end

      spawn_x = originX + COORD_W'(OFFSET_X);
      spawn_y = (pos_t'(originY) <<< FRAC_BITS) + OFFSET_Y_FX;
   end

   // -------------------------------------------------------------------------
   // Per-slot next state. Priority: hit > spawn > move.
   // A cleared slot also zeroes its position, so an inactive slot reads 0.
   // -------------------------------------------------------------------------
   always_comb begin
      y_next     = '0;
      off_screen = 1'b0;
      count_d    = '0;
      for (int i = 0; i < NUM_BOLTS; i++) begin
         pos_x_d[i]  = pos_x_q[i];
         pos_y_d[i]  = pos_y_q[i];
         active_d[i] = active_q[i];

         y_next     = pos_y_q[i] + STEP_Y;
         off_screen = (DIRECTION < 0) ? (y_next < Y_MIN_FX) : (y_next > Y_MAX_FX);

         if (boltHit[i] && active_q[i]) begin
            active_d[i] = 1'b0;
            pos_x_d[i]  = '0;
            pos_y_d[i]  = '0;
         end else if (accept && spawn_sel[i]) begin
            // A spawn in a frame-start cycle stays at the spawn point.
            active_d[i] = 1'b1;
            pos_x_d[i]  = spawn_x;
            pos_y_d[i]  = spawn_y;
         end else if (active_q[i] && startOfFrame) begin
            if (off_screen) begin
               active_d[i] = 1'b0;
               pos_x_d[i]  = '0;
               pos_y_d[i]  = '0;
            end else begin
               pos_y_d[i] = y_next;
            end
         end

         count_d = count_d + CNT_W'(active_d[i]);
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge.
   // NOTE: the slot positions are reset together with the control flags. The
   // outputs must read zero right after reset, so a mid-flight reset leaves
   // no stale coordinates.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_q   <= '0;
         fire_req_q <= 1'b0;
         cooldown_q <= '0;
         fire_acc_q <= 1'b0;
         count_q    <= '0;
         for (int i = 0; i < NUM_BOLTS; i++) begin
            pos_x_q[i] <= '0;
            pos_y_q[i] <= '0;
         end
      end else begin
         active_q   <= active_d;
         fire_req_q <= fire_req_d;
         cooldown_q <= cooldown_d;
         fire_acc_q <= fire_acc_d;
         count_q    <= count_d;
         for (int i = 0; i < NUM_BOLTS; i++) begin
            pos_x_q[i] <= pos_x_d[i];
            pos_y_q[i] <= pos_y_d[i];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: plain slices of registered state
   // -------------------------------------------------------------------------
   always_comb begin
      boltX = '0;
      boltY = '0;
      for (int i = 0; i < NUM_BOLTS; i++) begin
         boltX[i*COORD_W +: COORD_W] = pos_x_q[i];
         boltY[i*COORD_W +: COORD_W] = pos_y_q[i][FRAC_BITS +: COORD_W];
      end
   end

   assign boltActive   = active_q;
   assign fireAccepted = fire_acc_q;
   assign activeCount  = count_q;

endmodule
